// File: rtl/vga_pkg.sv
// Shared definitions for the VGA line-buffer fetch path.
// Holds the AXI burst/response encodings used by the fetch scheduler,
// the scheduler state encoding, and a constant-evaluable ceiling-log2 helper
// for sizing index fields and the AXI size code.
package vga_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FREE,
        ADDR,
        DATA
    } state_t;

    // Smallest r such that 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/vga_addr_gen.sv
// Frame address generator for the line-buffer fetch scheduler.
// Keeps the address of the next burst inside the frame region [base, top).
// Ports:
//   clk_a      - AXI clock
//   reset_a    - synchronous active-high reset
//   load       - take base_addr as the next burst address
//   advance    - step by one burst, wrapping to base_addr at or beyond top_addr
//   base_addr  - frame start address
//   top_addr   - frame end address (exclusive)
//   next_addr  - address of the next burst to issue
module vga_addr_gen #(
    parameter int          ADDR_WIDTH  = 64,
    parameter int unsigned BURST_BYTES = 256
) (
    input  logic                  clk_a,
    input  logic                  reset_a,
    input  logic                  load,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] top_addr,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    localparam logic [ADDR_WIDTH:0] STEP = (ADDR_WIDTH + 1)'(BURST_BYTES);

    // One extra bit so a sum that overflows the address space still wraps.
    logic [ADDR_WIDTH:0] sum;
    assign sum = {1'b0, next_addr} + STEP;

    // Load has priority; the two never coincide in the scheduler anyway.
    always_ff @(posedge clk_a) begin
        if (reset_a) begin
            next_addr <= '0;
        end else if (load) begin
            next_addr <= base_addr;
        end else if (advance) begin
            next_addr <= (sum >= {1'b0, top_addr}) ? base_addr : sum[ADDR_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/vga_fetch_scheduler.sv
// VGA line-buffer fetch scheduler.
// Issues fixed-length AXI INCR read bursts that fill the ping/pong halves of
// the line buffer from the frame region, and tracks which halves are full.
// A half is only filled when empty; the display side hands it back with a
// release pulse once consumed.
// Ports:
//   clk_a, reset_a                 - AXI clock, synchronous active-high reset
//   enable_i                       - fetching runs while high
//   base_addr_i, top_addr_i        - frame region [base, top)
//   buf_release_i, rel_sel_i       - display side frees a half (0 ping, 1 pong)
//   ar*                            - AXI read address channel (master side)
//   r*                             - AXI read data channel (master side)
//   wr_en_o/wr_sel_o/wr_idx_o/wr_data_o - line-buffer write port
//   buf_valid_o                    - per-half full flags
//   fill_sel_o                     - half that is filled next
//   busy_o                         - high while not IDLE
//   err_o                          - sticky error (bad rresp or rlast misplacement)
module vga_fetch_scheduler
    import vga_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 64,
    parameter  int DATA_WIDTH  = 64,
    parameter  int BURST_LEN   = 32,
    localparam int IDX_W       = (clog2(BURST_LEN) < 1) ? 1 : clog2(BURST_LEN),
    localparam int BURST_BYTES = BURST_LEN * DATA_WIDTH / 8
) (
    input  logic                  clk_a,
    input  logic                  reset_a,
    input  logic                  enable_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] top_addr_i,
    input  logic                  buf_release_i,
    input  logic                  rel_sel_i,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic [7:0]            arlen_o,
    output logic [2:0]            arsize_o,
    output logic [1:0]            arburst_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    output logic                  wr_en_o,
    output logic                  wr_sel_o,
    output logic [IDX_W-1:0]      wr_idx_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic [1:0]            buf_valid_o,
    output logic                  fill_sel_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

    state_t                  state;
    logic [IDX_W-1:0]        beat_cnt;
    logic [1:0]              buf_valid;
    logic                    fill_sel;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic                    beat;
    logic                    last_beat;
    logic                    addr_load;

    // Burst shape never changes, so these are tied off rather than registered.
    assign arlen_o   = 8'(BURST_LEN - 1);
    assign arsize_o  = 3'(clog2(DATA_WIDTH / 8));
    assign arburst_o = BURST_INCR;

    assign beat      = (state == DATA) && rvalid_i && rready_o;
    assign last_beat = beat && (beat_cnt == LAST_IDX);
    assign addr_load = (state == IDLE) && enable_i;

    assign buf_valid_o = buf_valid;
    assign fill_sel_o  = fill_sel;
    assign busy_o      = (state != IDLE);

    vga_addr_gen #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BURST_BYTES (BURST_BYTES)
    ) u_addr_gen (
        .clk_a     (clk_a),
        .reset_a   (reset_a),
        .load      (addr_load),
        .advance   (last_beat),
        .base_addr (base_addr_i),
        .top_addr  (top_addr_i),
        .next_addr (next_addr)
    );

    // Main sequencer. The release clear is written before the state case so
    // that a burst completion on the same half in the same cycle overrides it.
    always_ff @(posedge clk_a) begin
        if (reset_a) begin
            state     <= IDLE;
            araddr_o  <= '0;
            arvalid_o <= 1'b0;
            rready_o  <= 1'b0;
            beat_cnt  <= '0;
            wr_en_o   <= 1'b0;
            wr_sel_o  <= 1'b0;
            wr_idx_o  <= '0;
            wr_data_o <= '0;
            buf_valid <= 2'b00;
            fill_sel  <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            wr_en_o <= 1'b0;

            if (buf_release_i && (state != IDLE)) begin
                buf_valid[rel_sel_i] <= 1'b0;
            end

            case (state)
                IDLE: begin
                    buf_valid <= 2'b00;
                    fill_sel  <= 1'b0;
                    if (enable_i) begin
                        state <= WAIT_FREE;
                    end
                end

                WAIT_FREE: begin
                    if (!enable_i) begin
                        state     <= IDLE;
                        buf_valid <= 2'b00;
                        fill_sel  <= 1'b0;
                    end else if (!buf_valid[fill_sel]) begin
                        araddr_o  <= next_addr;
                        arvalid_o <= 1'b1;
                        state     <= ADDR;
                    end
                end

                ADDR: begin
                    if (arready_i) begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= DATA;
                    end
                end

                DATA: begin
                    if (beat) begin
                        wr_en_o   <= 1'b1;
                        wr_sel_o  <= fill_sel;
                        wr_idx_o  <= beat_cnt;
                        wr_data_o <= rdata_i;
                        beat_cnt  <= beat_cnt + 1'b1;
                        if (rresp_i != RESP_OKAY) begin
                            err_o <= 1'b1;
                        end
                        // Completion follows the beat count; rlast is only cross-checked.
                        if (rlast_i != (beat_cnt == LAST_IDX)) begin
                            err_o <= 1'b1;
                        end
                        if (beat_cnt == LAST_IDX) begin
                            rready_o            <= 1'b0;
                            buf_valid[fill_sel] <= 1'b1;
                            fill_sel            <= ~fill_sel;
                            state               <= WAIT_FREE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/vga_fetch_scheduler.md
Name: vga_fetch_scheduler

Overview:
- Sequences AXI read bursts that fill the two halves (ping/pong) of the VGA line buffer from the SDRAM frame region [base, top).
- Tracks the ownership of each half: it fills a half only when that half is empty, and the display side hands a half back once it has consumed it.
- Sits in the AXI clock domain, between the config unit, the AXI read channels and the line buffer's write port. Release pulses from the display side arrive already synchronized.

Parameters:
- ADDR_WIDTH, 64, AXI address width.
- DATA_WIDTH, 64, AXI read data width; must be a power of two and at least 8.
- BURST_LEN, 32, beats per burst, which is also the number of entries per buffer half (1..256).
- Derived localparams, not overridable: IDX_W = clog2(BURST_LEN); BURST_BYTES = BURST_LEN*DATA_WIDTH/8.

Ports:
- clk_a  in  1  AXI clock; the block's only clock.
- reset_a  in  1  synchronous, active-high reset.
- enable_i  in  1  level; fetching runs while this is high.
- base_addr_i  in  ADDR_WIDTH  frame start address, BURST_BYTES aligned.
- top_addr_i  in  ADDR_WIDTH  frame end address (exclusive).
- buf_release_i  in  1  one-cycle pulse: the display side has finished a half.
- rel_sel_i  in  1  which half is released (0 = ping, 1 = pong).
- araddr_o  out  ADDR_WIDTH;  arlen_o  out  8;  arsize_o  out  3;  arburst_o  out  2;  arvalid_o  out  1;  arready_i  in  1.
- rdata_i  in  DATA_WIDTH;  rresp_i  in  2;  rlast_i  in  1;  rvalid_i  in  1;  rready_o  out  1.
- wr_en_o  out  1;  wr_sel_o  out  1;  wr_idx_o  out  IDX_W;  wr_data_o  out  DATA_WIDTH.  Line-buffer write port.
- buf_valid_o  out  2  per-half full flag.
- fill_sel_o  out  1  the half that is filled next.
- busy_o  out  1  high while not IDLE.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0, except:
  - arlen_o = BURST_LEN-1;
  - arsize_o = log2(DATA_WIDTH/8) (3 at the default width);
  - arburst_o = 2'b01 (INCR).
  - arlen_o, arsize_o and arburst_o are constant after reset. The state register resets to IDLE.
- IDLE:
  - buf_valid is held at 0 and fill_sel at 0.
  - When enable_i is high: latch next_addr <= base_addr_i and move to WAIT_FREE.
- WAIT_FREE:
  - If enable_i is low, go to IDLE.
  - Else, if buf_valid[fill_sel] == 0: araddr_o <= next_addr, arvalid_o <= 1, go to ADDR.
- ADDR:
  - arvalid_o and araddr_o are held stable until arready_i is high.
  - On the handshake: arvalid_o <= 0, rready_o <= 1, beat_cnt <= 0, go to DATA.
  - A handshake is allowed in the same cycle that arvalid_o is first seen high.
- DATA, on each beat (rvalid_i & rready_o):
  - Next cycle: wr_en_o = 1, wr_sel_o = fill_sel, wr_idx_o = beat_cnt, wr_data_o = rdata_i. Write latency is exactly 1 cycle; there is no buffering beyond this.
  - beat_cnt increments.
  - rresp_i != 0 sets err_o, and the data is still written.
  - The final beat is beat_cnt == BURST_LEN-1. If rlast_i disagrees with beat_cnt, err_o is set; beat_cnt alone governs completion.
- Final beat actions:
  - rready_o <= 0; buf_valid[fill_sel] <= 1; fill_sel toggles.
  - next_addr <= (next_addr + BURST_BYTES >= top_addr_i) ? base_addr_i : next_addr + BURST_BYTES. Compute the sum at ADDR_WIDTH+1 bits so an overflow also wraps.
  - Go to WAIT_FREE; that state's own check returns to IDLE if enable_i is low.
- enable_i deasserted mid-burst: the burst completes normally, because AXI cannot abort it; the return to IDLE follows.
- buf_release_i clears buf_valid[rel_sel_i] in the next cycle.
  - If a release and a burst completion hit the same half in the same cycle, the set wins.
  - A release while IDLE is ignored.
- err_o is cleared only by reset_a.
- reset_a asserted mid-burst returns to IDLE immediately with reset values. The AXI slave is reset on the same reset, so no outstanding beats remain.
- base_addr_i and top_addr_i are sampled only on leaving IDLE and at wrap; changes at other times take effect at the next wrap.

Decomposition:
- Package vga_pkg holds:
  - AXI constants: BURST_INCR = 2'b01, RESP_OKAY = 2'b00;
  - the state enum {IDLE, WAIT_FREE, ADDR, DATA};
  - a clog2 function.
- One sub-module, vga_addr_gen: holds next_addr and implements the load-base and advance-with-wrap operations (parameter ADDR_WIDTH, BURST_BYTES).

Test Plan:
- Reset then enable, base=0x1000, top=0x1400, arready=1, rvalid always high. Required: bursts at 0x1000 and 0x1100 fill both halves. buf_valid=2'b11 and arvalid_o stays low until a release.
- Release half 0. Required: the next burst goes to araddr 0x1200 with wr_sel=0; after 0x1300 the address wraps to 0x1000.
- Hold arready_i low for 5 cycles in ADDR. Required: araddr_o and arvalid_o are stable throughout, and the handshake happens on the cycle arready rises.
- rresp=2'b10 on beat 7. Required: data is still written to wr_idx 7, err_o rises and stays high until reset.
- Deassert enable_i at beat 10. Required: beats 10..31 are all written, then IDLE with busy_o=0 and buf_valid=0.
- Assert reset_a at beat 15. Required: the next cycle shows arvalid_o=0, rready_o=0, wr_en_o=0, buf_valid=0 and state IDLE.
